// File: rtl/uart_rx_packetizer.sv
// uart_rx_packetizer
//   Consumes the UART receiver byte stream, hunts for SYNC_BYTE, collects a
//   length-prefixed payload and verifies an 8-bit wrap-around checksum. The
//   checksum is seeded with the length byte. Good frames are buffered and
//   replayed as a valid/ready stream with a last flag. Bad frames are dropped
//   and flagged on frame_err_o.
//
//   Optional feature: define UART_RX_PACKETIZER_TIMEOUT_EN to abort a partial
//   frame after TIMEOUT_CYCLES idle clocks between bytes.
//
// Ports
//   clk_i         system clock
//   rst_n_i       asynchronous active-low reset
//   rx_data_i     byte from the UART receiver
//   rx_data_i_v   one-cycle strobe, rx_data_i valid
//   data_o        payload byte to the core
//   data_o_v      data_o valid
//   data_o_last   high with the final payload byte of a frame
//   data_o_rdy_i  core ready, transfer on data_o_v & data_o_rdy_i
//   frame_err_o   one-cycle pulse: bad length, checksum fail or timeout
//   overrun_o     one-cycle pulse: byte discarded while replaying a frame
module uart_rx_packetizer #(
  parameter int unsigned               DATA_LENGTH    = 8,
  parameter logic [DATA_LENGTH-1:0]    SYNC_BYTE      = 8'hA5,
  parameter int unsigned               MAX_LEN        = 16,
  parameter int unsigned               TIMEOUT_CYCLES = 20000
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [DATA_LENGTH-1:0] rx_data_i,
  input  logic                   rx_data_i_v,
  output logic [DATA_LENGTH-1:0] data_o,
  output logic                   data_o_v,
  output logic                   data_o_last,
  input  logic                   data_o_rdy_i,
  output logic                   frame_err_o,
  output logic                   overrun_o
);

  localparam int unsigned CW = $clog2(MAX_LEN + 1);
  localparam int unsigned IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [DATA_LENGTH-1:0] MAX_LEN_B = DATA_LENGTH'(MAX_LEN);

  typedef enum logic [2:0] {
    ST_SYNC,
    ST_LEN,
    ST_PAYLOAD,
    ST_CSUM,
    ST_OUT
  } state_t;

  state_t                 state;
  logic [CW-1:0]          len;
  logic [CW-1:0]          idx;
  logic [CW-1:0]          rd_idx;
  logic [DATA_LENGTH-1:0] csum;
  logic [DATA_LENGTH-1:0] pbuf [MAX_LEN];

  logic [CW-1:0]          len_m1;
  logic [CW-1:0]          rd_nxt;
  logic [DATA_LENGTH-1:0] csum_sum;
  logic                   len_ok;

  assign len_m1   = len - CW'(1);
  assign rd_nxt   = rd_idx + CW'(1);
  assign csum_sum = csum + rx_data_i;
  assign len_ok   = (rx_data_i != '0) && (rx_data_i <= MAX_LEN_B);

`ifdef UART_RX_PACKETIZER_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] tmo;
  logic          in_frame;
  logic          tmo_hit;

  assign in_frame = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CSUM);
  assign tmo_hit  = in_frame && !rx_data_i_v && (tmo == TW'(TIMEOUT_CYCLES - 1));
`endif

  // Payload storage; contents are don't-care after reset so no reset term.
  always_ff @(posedge clk_i) begin
    if (state == ST_PAYLOAD && rx_data_i_v) begin
      pbuf[idx[IW-1:0]] <= rx_data_i;
    end
  end

  // Frame FSM with registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= ST_SYNC;
      len         <= '0;
      idx         <= '0;
      rd_idx      <= '0;
      csum        <= '0;
      data_o      <= '0;
      data_o_v    <= 1'b0;
      data_o_last <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
`ifdef UART_RX_PACKETIZER_TIMEOUT_EN
      tmo         <= '0;
`endif
    end else begin
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;

      case (state)
        ST_SYNC: begin
          if (rx_data_i_v && (rx_data_i == SYNC_BYTE)) begin
            state <= ST_LEN;
          end
        end

        ST_LEN: begin
          if (rx_data_i_v) begin
            if (len_ok) begin
              len   <= CW'(rx_data_i);
              csum  <= rx_data_i;
              idx   <= '0;
              state <= ST_PAYLOAD;
            end else begin
              frame_err_o <= 1'b1;
              state       <= ST_SYNC;
            end
          end
        end

        ST_PAYLOAD: begin
          if (rx_data_i_v) begin
            csum <= csum_sum;
            idx  <= idx + CW'(1);
            if (idx == len_m1) begin
              state <= ST_CSUM;
            end
          end
        end

        ST_CSUM: begin
          if (rx_data_i_v) begin
            if (csum_sum == '0) begin
              // Present the first byte right away so valid rises next cycle.
              state       <= ST_OUT;
              rd_idx      <= '0;
              data_o      <= pbuf[0];
              data_o_v    <= 1'b1;
              data_o_last <= (len == CW'(1));
            end else begin
              frame_err_o <= 1'b1;
              state       <= ST_SYNC;
            end
          end
        end

        ST_OUT: begin
          if (rx_data_i_v) begin
            overrun_o <= 1'b1;
          end
          if (data_o_rdy_i) begin
            if (data_o_last) begin
              data_o_v    <= 1'b0;
              data_o_last <= 1'b0;
              state       <= ST_SYNC;
            end else begin
              rd_idx      <= rd_nxt;
              data_o      <= pbuf[rd_nxt[IW-1:0]];
              data_o_last <= (rd_nxt == len_m1);
            end
          end
        end

        default: state <= ST_SYNC;
      endcase

`ifdef UART_RX_PACKETIZER_TIMEOUT_EN
      // Inter-byte watchdog; overrides the case above when it fires.
      if (rx_data_i_v || !in_frame || tmo_hit) begin
        tmo <= '0;
      end else begin
        tmo <= tmo + TW'(1);
      end
      if (tmo_hit) begin
        frame_err_o <= 1'b1;
        state       <= ST_SYNC;
      end
`endif
    end
  end

endmodule
